// File: rtl/pulse_cmd_sender_if.sv
// pulse_cmd_sender_if: command handshake, UART byte strobes and echo status of pulse_cmd_sender
// Ports: master = host/UART side driving commands and RX/TX status; slave = pulse_cmd_sender.
interface pulse_cmd_sender_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic [7:0]  cmd_ctrl;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        is_transmitting;
  logic        received;
  logic [7:0]  rx_byte;
  logic        recv_error;
  logic        busy;
  logic        done;
  logic        ack_ok;
  logic        ack_err;
  logic        ack_timeout;
  logic [7:0]  echo_byte;
  modport master (
    output cmd_valid, cmd_data, cmd_ctrl, is_transmitting, received, rx_byte, recv_error,
    input  cmd_ready, transmit, tx_byte, busy, done, ack_ok, ack_err, ack_timeout, echo_byte
  );
  modport slave (
    input  cmd_valid, cmd_data, cmd_ctrl, is_transmitting, received, rx_byte, recv_error,
    output cmd_ready, transmit, tx_byte, busy, done, ack_ok, ack_err, ack_timeout, echo_byte
  );
endinterface

// File: rtl/pulse_cmd_sender.sv
// pulse_cmd_sender: sends a 5-byte UART command frame and checks the peer's checksum echo
// Ports: clk; rst_n (async, active-low); bus (pulse_cmd_sender_if.slave: command handshake,
//   UART transmit/receive strobes, busy/done/ack status, echo_byte).
// Define CMD_TIMEOUT_EN to give up on the echo after TIMEOUT_CYCLES cycles in RX_WAIT.
module pulse_cmd_sender #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_000_000
) (
  input logic clk,
  input logic rst_n,
  pulse_cmd_sender_if.slave bus
);
  typedef enum logic [2:0] {IDLE, TX_WAIT, TX_GUARD, TX_BUSY, RX_WAIT, DONE} state_t;
  state_t state;
  logic [31:0] data;
  logic [7:0] ctrl, sum, cur;
  logic [2:0] idx;
  always_comb cur = idx == 3'd4 ? ctrl : data[{idx[1:0], 3'b000} +: 8];
  // strobe is decoded from state so it can fire the cycle after accept and drops with reset
  assign bus.transmit = state == TX_WAIT && !bus.is_transmitting;
  assign bus.tx_byte = bus.transmit ? cur : 8'h00;
  assign bus.cmd_ready = state == IDLE;
  assign bus.busy = state != IDLE;
`ifdef CMD_TIMEOUT_EN
  logic [31:0] cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign bus.ack_timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      data <= '0;
      ctrl <= '0;
      sum <= '0;
      idx <= '0;
      bus.done <= 1'b0;
      bus.ack_ok <= 1'b0;
      bus.ack_err <= 1'b0;
      bus.echo_byte <= '0;
`ifdef CMD_TIMEOUT_EN
      cnt <= '0;
      bus.ack_timeout <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          data <= bus.cmd_data;
          ctrl <= bus.cmd_ctrl;
          sum <= bus.cmd_data[31:24] + bus.cmd_data[23:16] + bus.cmd_data[15:8] + bus.cmd_data[7:0];
          idx <= '0;
          bus.ack_ok <= 1'b0;
          bus.ack_err <= 1'b0;
`ifdef CMD_TIMEOUT_EN
          bus.ack_timeout <= 1'b0;
`endif
          state <= TX_WAIT;
        end
        TX_WAIT: if (!bus.is_transmitting) state <= TX_GUARD;
        TX_GUARD: state <= TX_BUSY;
        TX_BUSY: if (!bus.is_transmitting) begin
          idx <= idx + 3'd1;
          state <= idx == 3'd4 ? RX_WAIT : TX_WAIT;
`ifdef CMD_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        // a framing error outranks a byte arriving in the same cycle, but the byte is still kept
        RX_WAIT: if (bus.received || bus.recv_error) begin
          if (bus.received) bus.echo_byte <= bus.rx_byte;
          bus.ack_ok <= !bus.recv_error && bus.rx_byte == sum;
          bus.ack_err <= bus.recv_error || bus.rx_byte != sum;
          bus.done <= 1'b1;
          state <= DONE;
        end
`ifdef CMD_TIMEOUT_EN
        else if (cnt == TIMEOUT_CYCLES - 32'd1) begin
          bus.ack_timeout <= 1'b1;
          bus.done <= 1'b1;
          state <= DONE;
        end else cnt <= cnt + 32'd1;
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pulse_cmd_sender.sv
// tb_pulse_cmd_sender: randomized frame/echo stimulus checked against a byte-stream and ack model
module tb_pulse_cmd_sender;
  localparam logic [31:0] TO = 32'd1000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pulse_cmd_sender_if bus();
  pulse_cmd_sender #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_done_cyc = -1;
  int stall_next = 0;
  bit spur_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  logic [7:0] cur_sum = 8'h00;
  logic exp_ok = 1'b0, exp_err = 1'b0, exp_to = 1'b0;
  logic [7:0] exp_echo = 8'h00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] csum(input logic [31:0] d);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 4; i++) s += d[8*i +: 8];
    return s;
  endfunction

  always @(negedge clk) if (rst_n) begin
    cyc++;
    chk("busy_vs_ready", bus.busy, !bus.cmd_ready);
    chk("done_timing", bus.done, cyc == exp_done_cyc);
    if (bus.done) begin
      chk("done_ack_ok", bus.ack_ok, exp_ok);
      chk("done_ack_err", bus.ack_err, exp_err);
      chk("done_ack_timeout", bus.ack_timeout, exp_to);
      chk("done_echo", bus.echo_byte, exp_echo);
    end
    if (bus.cmd_ready) begin
      chk("hold_ack_ok", bus.ack_ok, exp_ok);
      chk("hold_ack_err", bus.ack_err, exp_err);
      chk("hold_ack_timeout", bus.ack_timeout, exp_to);
      chk("hold_echo", bus.echo_byte, exp_echo);
    end
    if (bus.transmit) begin
      chk("tx_while_uart_busy", bus.is_transmitting, 0);
      chk("tx_pending", exp_q.size() > 0, 1);
      got.push_back(bus.tx_byte);
      if (exp_q.size() > 0) chk("tx_byte", bus.tx_byte, exp_q.pop_front());
    end
  end

  // UART peer: busy for a random frame time after each strobe, optionally busy on its own
  initial begin
    bus.is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.transmit) begin
        @(posedge clk);
        #1 bus.is_transmitting = 1'b1;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        repeat (stall_next) @(posedge clk);
        #1 bus.is_transmitting = 1'b0;
      end else if (spur_en && $urandom_range(0, 9) == 0) begin
        @(posedge clk);
        #1 bus.is_transmitting = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 bus.is_transmitting = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic accept(input logic [31:0] d, input logic [7:0] c);
    int n = 0;
    while (!bus.cmd_ready && n < 5000) begin step(); n++; end
    chk("ready_before_accept", bus.cmd_ready, 1);
    for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
    exp_q.push_back(c);
    got.delete();
    cur_sum = csum(d);
    bus.cmd_data = d;
    bus.cmd_ctrl = c;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    chk("ready_after_accept", bus.cmd_ready, 0);
  endtask

  task automatic wait_frame_sent();
    int n = 0;
    while ((exp_q.size() != 0 || bus.is_transmitting) && n < 5000) begin step(); n++; end
    chk("frame_sent_in_time", n < 5000, 1);
  endtask

  task automatic echo(input logic [7:0] b, input bit rcv, input bit err, input int delay);
    repeat (1 + delay) step();
    bus.received = rcv;
    bus.recv_error = err;
    bus.rx_byte = b;
    exp_done_cyc = cyc + 2;
    exp_ok = rcv && !err && b == cur_sum;
    exp_err = err || (rcv && b != cur_sum);
    exp_to = 1'b0;
    if (rcv) exp_echo = b;
    step();
    bus.received = 1'b0;
    bus.recv_error = 1'b0;
    bus.rx_byte = 8'($urandom);
    chk("ready_echo_m1", bus.cmd_ready, 0);
    step();
    chk("ready_echo_m2", bus.cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, %0d checks so far", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    bus.cmd_valid = 1'b0;
    bus.cmd_data = '0;
    bus.cmd_ctrl = '0;
    bus.received = 1'b0;
    bus.recv_error = 1'b0;
    bus.rx_byte = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_transmit", bus.transmit, 0);
    chk("rst_tx_byte", bus.tx_byte, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_acks", {bus.ack_ok, bus.ack_err, bus.ack_timeout}, 3'b000);
    chk("rst_echo", bus.echo_byte, 0);
    rst_n = 1'b1;
    step();
    // loopback frame, first strobe the cycle after accept
    accept(32'h0000_00C8, 8'h00);
    chk("t1_first_tx", bus.transmit, 1);
    chk("t1_first_byte", bus.tx_byte, 8'hC8);
    wait_frame_sent();
    chk("t1_nbytes", got.size(), 5);
    chk("t1_bytes", {got[0], got[1], got[2], got[3], got[4]}, 40'hC8_0000_0000);
    echo(8'hC8, 1'b1, 1'b0, 0);
    chk("t1_ack_ok", bus.ack_ok, 1);
    chk("t1_echo", bus.echo_byte, 8'hC8);
    // checksum wrap
    chk("t2_model_sum", csum(32'hFFFF_FFFF), 8'hFC);
    accept(32'hFFFF_FFFF, 8'h07);
    wait_frame_sent();
    echo(8'hFC, 1'b1, 1'b0, 3);
    chk("t2_ack_ok", bus.ack_ok, 1);
    // mismatch
    chk("t3_model_sum", csum(32'h1234_5678), 8'h14);
    accept(32'h1234_5678, 8'h03);
    wait_frame_sent();
    echo(8'h00, 1'b1, 1'b0, 1);
    chk("t3_ack_err", bus.ack_err, 1);
    chk("t3_ack_ok", bus.ack_ok, 0);
    chk("t3_echo", bus.echo_byte, 8'h00);
    // UART held busy for 50 cycles before the third byte
    accept(32'hCAFE_1234, 8'h04);
    n = 0;
    while (exp_q.size() != 3 && n < 1000) begin step(); n++; end
    chk("t4_reached_byte2", n < 1000, 1);
    stall_next = 50;
    n = 0;
    repeat (50) begin step(); n += int'(bus.transmit); end
    stall_next = 0;
    chk("t4_no_tx_stalled", n, 0);
    wait_frame_sent();
    echo(cur_sum, 1'b1, 1'b0, 2);
    chk("t4_ack_ok", bus.ack_ok, 1);
`ifdef CMD_TIMEOUT_EN
    accept(32'h0BAD_F00D, 8'h01);
    wait_frame_sent();
    exp_done_cyc = cyc + 2 + int'(TO);
    exp_ok = 1'b0;
    exp_err = 1'b0;
    exp_to = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 3000) begin step(); n++; end
    chk("t5_timeout_ready", bus.cmd_ready, 1);
    chk("t5_ack_timeout", bus.ack_timeout, 1);
    chk("t5_ack_ok", bus.ack_ok, 0);
    accept(32'h0000_0101, 8'h02);
    wait_frame_sent();
    echo(8'h02, 1'b1, 1'b0, int'(TO) - 1);
    chk("t5_echo_wins_ok", bus.ack_ok, 1);
    chk("t5_echo_wins_to", bus.ack_timeout, 0);
`else
    accept(32'h0BAD_F00D, 8'h01);
    wait_frame_sent();
    n = 0;
    repeat (1200) begin step(); n += int'(!bus.busy); end
    chk("t5_busy_held", n, 0);
    echo(cur_sum, 1'b1, 1'b0, 0);
    chk("t5_ack_timeout", bus.ack_timeout, 0);
`endif
    // reset while the third byte is being strobed
    accept(32'hA1B2_C3D4, 8'h05);
    n = 0;
    while (!(exp_q.size() == 3 && bus.transmit) && n < 1000) begin step(); n++; end
    chk("t6_reached_byte3", n < 1000, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_transmit", bus.transmit, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_tx_byte", bus.tx_byte, 0);
    exp_q.delete();
    exp_done_cyc = -1;
    exp_ok = 1'b0;
    exp_err = 1'b0;
    exp_to = 1'b0;
    exp_echo = 8'h00;
    repeat (2) step();
    rst_n = 1'b1;
    n = 0;
    while (bus.is_transmitting && n < 100) begin step(); n++; end
    chk("t6_ready_after", bus.cmd_ready, 1);
    accept(32'h5566_7788, 8'h08);
    wait_frame_sent();
    chk("t6_full_frame", got.size(), 5);
    echo(cur_sum, 1'b1, 1'b0, 0);
    chk("t6_ack_ok", bus.ack_ok, 1);
    // randomized commands, echoes, stray RX strobes and UART busy periods
    spur_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      accept($urandom, 8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        bus.received = 1'b1;
        bus.recv_error = 1'($urandom);
        bus.rx_byte = 8'($urandom);
        step();
        bus.received = 1'b0;
        bus.recv_error = 1'b0;
      end
      wait_frame_sent();
      k = int'($urandom_range(0, 3));
      echo(k == 0 ? cur_sum : 8'($urandom), k != 2, k >= 2, int'($urandom_range(0, 8)));
    end
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
